// File: rtl/slave_fsm_if.sv
// Bus-side and datapath-side signals of the I2C slave controller, bundled for
// the slave block and for whatever models the bus master/datapath around it.
interface slave_fsm_if;
    logic       slave_scl_in;
    logic       slave_sda_in;
    logic       slave_sda_oe;
    logic [7:0] slave_rx_data;
    logic       slave_rx_valid;
    logic       slave_rx_ready;
    logic [7:0] slave_tx_data;
    logic       slave_tx_req;
    logic       slave_rd_wr;
    logic       slave_busy;

    // rx: slave_rx_valid is a one-cycle strobe with no back-pressure; slave_rx_ready
    // is only consulted at the ACK slot. tx: slave_tx_req asks for the next byte and
    // slave_tx_data must be stable by the following SCL fall, when it is loaded.
    modport slave (
        input  slave_scl_in, slave_sda_in, slave_rx_ready, slave_tx_data,
        output slave_sda_oe, slave_rx_data, slave_rx_valid, slave_tx_req,
        output slave_rd_wr, slave_busy
    );

    modport master (
        output slave_scl_in, slave_sda_in, slave_rx_ready, slave_tx_data,
        input  slave_sda_oe, slave_rx_data, slave_rx_valid, slave_tx_req,
        input  slave_rd_wr, slave_busy
    );
endinterface

// File: rtl/slave_fsm.sv
// I2C slave controller running on an oversampling clock; open-drain SDA only.
// Optional feature: define SLAVE_GEN_CALL_EN to also accept the general-call address 8'h00.
module slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic          slave_scl_sixt,
    input  logic          slave_rst,
    slave_fsm_if.slave    bus,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK_CHK, WAIT_STOP
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       byte_done;
    logic       ack_ok;
    logic       oe, rx_valid, tx_req, rd_wr, busy;
    logic [7:0] rx_data;

    logic       scl_rise, scl_fall, start_det, stop_det, addr_match;
    logic [7:0] rx_shift;

    // Synchronizers preset high so reset looks like an idle bus.
    always_ff @(posedge slave_scl_sixt) begin
        if (slave_rst) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            scl_s1 <= bus.slave_scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.slave_sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_shift  = {shreg[6:0], sda_s2};

`ifdef SLAVE_GEN_CALL_EN
    assign addr_match = (shreg[7:1] == SLAVE_ADDR) || (shreg == 8'h00);
`else
    assign addr_match = (shreg[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge slave_scl_sixt) begin
        if (slave_rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            byte_done <= 1'b0;
            ack_ok    <= 1'b0;
            oe        <= 1'b0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rd_wr     <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            // Bus conditions take priority over any SCL strobe in the same cycle.
            if (start_det) begin
                state     <= ADDR;
                oe        <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                oe        <= 1'b0;
                busy      <= 1'b0;
                byte_done <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_shift;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            bit_cnt   <= 3'd0;
                            if (addr_match) begin
                                state <= ADDR_ACK;
                                oe    <= 1'b1;
                                rd_wr <= shreg[0];
                                busy  <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                                oe    <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && rd_wr) begin
                            tx_req <= 1'b1;
                        end else if (scl_fall) begin
                            if (rd_wr) begin
                                state <= TX_DATA;
                                shreg <= bus.slave_tx_data;
                                oe    <= ~bus.slave_tx_data[7];
                            end else begin
                                state <= RX_DATA;
                                oe    <= 1'b0;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_shift;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= rx_shift;
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            ack_ok    <= bus.slave_rx_ready;
                            oe        <= bus.slave_rx_ready;
                            state     <= RX_ACK;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            oe    <= 1'b0;
                            state <= ack_ok ? RX_DATA : WAIT_STOP;
                        end
                    end
                    TX_DATA: begin
                        // Bit 7 is already on the bus at entry; each later fall presents the next bit.
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                oe        <= 1'b0;
                                state     <= TX_ACK_CHK;
                            end else begin
                                shreg <= {shreg[6:0], 1'b0};
                                oe    <= ~shreg[6];
                            end
                        end
                    end
                    TX_ACK_CHK: begin
                        // byte_done doubles as "master ACK seen" while in this state.
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                tx_req    <= 1'b1;
                                byte_done <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            shreg     <= bus.slave_tx_data;
                            oe        <= ~bus.slave_tx_data[7];
                            state     <= TX_DATA;
                        end
                    end
                    WAIT_STOP: begin
                        oe   <= 1'b0;
                        busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.slave_sda_oe   = oe;
    assign bus.slave_rx_data  = rx_data;
    assign bus.slave_rx_valid = rx_valid;
    assign bus.slave_tx_req   = tx_req;
    assign bus.slave_rd_wr    = rd_wr;
    assign bus.slave_busy     = busy;
    assign dbg_state          = state;

endmodule

// File: tb/tb_slave_fsm.sv
// Self-checking bench for slave_fsm: bit-banged I2C master on an open-drain bus,
// scoreboard queues for received and transmitted bytes.
module tb_slave_fsm;

    localparam int Q = 8;  // quarter SCL period in system clocks

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TX_DATA   = 3'd5;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [2:0] dbg_state;

    int chk_cnt = 0;
    int err_cnt = 0;
    int rx_cnt  = 0;
    int tx_cnt  = 0;
    logic oe_seen = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] rd_q[$];

    slave_fsm_if bus_if ();

    assign bus_if.slave_scl_in = scl_drv;
    assign bus_if.slave_sda_in = ~(m_sda_low | bus_if.slave_sda_oe);

    slave_fsm #(.SLAVE_ADDR(7'h50)) dut (
        .slave_scl_sixt (clk),
        .slave_rst      (rst),
        .bus            (bus_if.slave),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (bus_if.slave_rx_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else check("rx_data", {24'd0, bus_if.slave_rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (bus_if.slave_tx_req) tx_cnt++;
        if (bus_if.slave_sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; scl_drv = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        m_sda_low = 1'b0; wait_q(); wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl_drv = 1'b1; wait_q(); wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        b = bus_if.slave_sda_in;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack, input logic [7:0] next_tx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        bus_if.slave_tx_data = next_tx;
        send_bit(~ack);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tx0;

        bus_if.slave_rx_ready = 1'b1;
        bus_if.slave_tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_oe", bus_if.slave_sda_oe, 0);
        check("rst_busy", bus_if.slave_busy, 0);
        check("rst_rd_wr", bus_if.slave_rd_wr, 0);
        check("rst_rx_data", bus_if.slave_rx_data, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write 0x3C
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1);
        check("wr_busy", bus_if.slave_busy, 1);
        check("wr_rd_wr", bus_if.slave_rd_wr, 0);
        exp_q.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check("wr_data_ack", ack, 1);
        bus_stop();
        check("wr_busy_after_stop", bus_if.slave_busy, 0);
        check("wr_state_idle", dbg_state, S_IDLE);
        check("wr_rx_data", bus_if.slave_rx_data, 8'h3C);
        check("wr_rx_pulses", rx_cnt - rx0, 1);

        // Read 0x96 then 0x5A
        tx0 = tx_cnt;
        bus_if.slave_tx_data = 8'h96;
        rd_q.push_back(8'h96);
        rd_q.push_back(8'h5A);
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1);
        check("rd_rd_wr", bus_if.slave_rd_wr, 1);
        read_byte(d, 1'b1, 8'h5A);
        check("rd_byte0", d, rd_q.pop_front());
        read_byte(d, 1'b0, 8'h00);
        check("rd_byte1", d, rd_q.pop_front());
        check("rd_wait_stop", dbg_state, S_WAIT_STOP);
        check("rd_tx_req_pulses", tx_cnt - tx0, 2);
        bus_stop();
        check("rd_state_idle", dbg_state, S_IDLE);

        // Address miss
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'hA2, ack);
        check("miss_ack", ack, 0);
        check("miss_busy", bus_if.slave_busy, 0);
        check("miss_state", dbg_state, S_WAIT_STOP);
        bus_stop();
        check("miss_oe_never", oe_seen, 0);
        check("miss_state_idle", dbg_state, S_IDLE);

        // Back-pressure
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("bp_addr_ack", ack, 1);
        bus_if.slave_rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        write_byte(8'h11, ack);
        check("bp_data_nack", ack, 0);
        check("bp_state", dbg_state, S_WAIT_STOP);
        bus_if.slave_rx_ready = 1'b1;
        write_byte(8'h22, ack);
        check("bp_ignored_nack", ack, 0);
        bus_stop();
        check("bp_rx_pulses", rx_cnt - rx0, 1);

        // Repeated START four bits into a data byte
        bus_start();
        write_byte(8'hA0, ack);
        check("rs_addr0_ack", ack, 1);
        for (int i = 0; i < 4; i++) send_bit(($urandom_range(0, 1) == 1));
        bus_if.slave_tx_data = 8'hC3;
        rd_q.push_back(8'hC3);
        bus_rstart();
        write_byte(8'hA1, ack);
        check("rs_addr1_ack", ack, 1);
        check("rs_rd_wr", bus_if.slave_rd_wr, 1);
        check("rs_state", dbg_state, S_TX_DATA);
        read_byte(d, 1'b0, 8'h00);
        check("rs_byte", d, rd_q.pop_front());
        bus_stop();

        // Reset in the middle of a read while SDA is pulled low
        bus_if.slave_tx_data = 8'h00;
        bus_start();
        write_byte(8'hA1, ack);
        check("mr_addr_ack", ack, 1);
        check("mr_oe_driving", bus_if.slave_sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_oe", bus_if.slave_sda_oe, 0);
        check("mr_state", dbg_state, S_IDLE);
        check("mr_busy", bus_if.slave_busy, 0);
        check("mr_rd_wr", bus_if.slave_rd_wr, 0);
        rst = 1'b0;
        bus_stop();

        // General call address 0x00, and 0x01 which never matches
        bus_start();
        write_byte(8'h00, ack);
`ifdef SLAVE_GEN_CALL_EN
        check("gc_ack", ack, 1);
        exp_q.push_back(8'h5E);
        write_byte(8'h5E, ack);
        check("gc_data_ack", ack, 1);
`else
        check("gc_nack", ack, 0);
`endif
        bus_stop();
        bus_start();
        write_byte(8'h01, ack);
        check("gc_read_nack", ack, 0);
        bus_stop();

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
